// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and line-select constants for the UART TX frame controller
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: combinational parity of the data byte, even (typ=0) or odd (typ=1)
module uart_tx_parity_calc #(
    parameter int DATA_SIZE = 8
) (
    input  logic [DATA_SIZE-1:0] data,
    input  logic                 par_typ,
    output logic                 par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: UART TX frame sequencer (start, data, optional parity, stop) with DATA watchdog.
// Parity state, latch and calculator exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int WDOG_SLACK = 2
) (
    input  logic                 CLK_FSM,
    input  logic                 RST_FSM,
    input  logic [DATA_SIZE-1:0] P_DATA_FSM,
    input  logic                 Data_Valid_FSM,
    input  logic                 PAR_EN_FSM,
    input  logic                 PAR_TYP_FSM,
    input  logic                 ser_done_FSM,
    input  logic                 ser_data_FSM,
    output logic                 ser_en_FSM,
    output logic [1:0]           mux_sel_FSM,
    output logic                 Busy_FSM,
    output logic                 TX_OUT_FSM,
    output logic                 frame_err_FSM
);

    localparam int WDOG_LIMIT = DATA_SIZE + WDOG_SLACK;
    localparam int WW         = $clog2(WDOG_LIMIT + 1);

    state_t        state, state_nx;
    logic [WW-1:0] wdog;
    logic          wdog_hit, abort, par_bit, par_en, mux_line;

`ifdef UART_TX_PARITY_EN
    logic par_calc;

    uart_tx_parity_calc #(.DATA_SIZE(DATA_SIZE)) u_parity (
        .data    (P_DATA_FSM),
        .par_typ (PAR_TYP_FSM),
        .par_bit (par_calc)
    );

    // capture parity bit and enable at accept so later input changes cannot disturb the frame
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            par_bit <= 1'b0;
            par_en  <= 1'b0;
        end else if (state == IDLE && Data_Valid_FSM) begin
            par_bit <= par_calc;
            par_en  <= PAR_EN_FSM;
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{P_DATA_FSM, PAR_EN_FSM, PAR_TYP_FSM};
    assign par_bit    = 1'b0;
    assign par_en     = 1'b0;
`endif

    // last permitted DATA cycle; ser_done in the same cycle still takes priority
    assign wdog_hit = (wdog == WW'(WDOG_LIMIT - 1));
    assign abort    = (state == DATA) && !ser_done_FSM && wdog_hit;

    // state register
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) state <= IDLE;
        else          state <= state_nx;
    end

    // DATA-cycle watchdog, zero whenever the next cycle is not a continuing DATA cycle
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) wdog <= '0;
        else          wdog <= (state == DATA && state_nx == DATA) ? wdog + 1'b1 : '0;
    end

    // registered line and abort pulse; TX follows the mux one cycle behind the state
    always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
        if (!RST_FSM) begin
            TX_OUT_FSM    <= 1'b1;
            frame_err_FSM <= 1'b0;
        end else begin
            TX_OUT_FSM    <= mux_line;
            frame_err_FSM <= abort;
        end
    end

    // next state and Moore outputs decoded from the state register
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Data_Valid_FSM ? START : IDLE;
            START:   state_nx = DATA;
            DATA:    state_nx = ser_done_FSM ? (par_en ? PARITY : STOP) : (wdog_hit ? STOP : DATA);
            PARITY:  state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        ser_en_FSM  = (state == DATA);
        Busy_FSM    = (state != IDLE);
        mux_sel_FSM = (state == START)  ? MUX_START :
                      (state == DATA)   ? MUX_DATA  :
                      (state == PARITY) ? MUX_PAR   : MUX_STOP;
        mux_line    = (mux_sel_FSM == MUX_START) ? 1'b0         :
                      (mux_sel_FSM == MUX_DATA)  ? ser_data_FSM :
                      (mux_sel_FSM == MUX_PAR)   ? par_bit      : 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: scoreboard bench for the UART TX frame sequencer with a model serializer
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] p_data = 8'h00, ser_byte = 8'h00;
    logic       dv = 1'b0, pen = 1'b0, ptyp = 1'b0, stuck = 1'b0;
    logic       ser_done, ser_data, ser_en, busy, tx, ferr;
    logic [1:0] mux_sel;
    logic [3:0] idx = 4'd0;
    int         total = 0, bad = 0;
    bit         exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.DATA_SIZE(8), .WDOG_SLACK(2)) dut (
        .CLK_FSM        (clk),
        .RST_FSM        (rst_n),
        .P_DATA_FSM     (p_data),
        .Data_Valid_FSM (dv),
        .PAR_EN_FSM     (pen),
        .PAR_TYP_FSM    (ptyp),
        .ser_done_FSM   (ser_done),
        .ser_data_FSM   (ser_data),
        .ser_en_FSM     (ser_en),
        .mux_sel_FSM    (mux_sel),
        .Busy_FSM       (busy),
        .TX_OUT_FSM     (tx),
        .frame_err_FSM  (ferr)
    );

    // model serializer: presents bit idx while enabled, reports done on the last data bit
    always @(posedge clk) idx <= ser_en ? idx + 4'd1 : 4'd0;
    assign ser_data = (idx < 4'd8) ? ser_byte[idx[2:0]] : 1'b0;
    assign ser_done = ser_en && (idx == 4'd7) && !stuck;

    task automatic push_exp(input logic [7:0] b, input bit pe, input bit pt, input bit stk);
        exp_q.push_back(1'b0);
        for (int i = 0; i < (stk ? 10 : 8); i++) exp_q.push_back(i < 8 ? b[i] : 1'b0);
        if (!stk && pe && HAS_PAR) exp_q.push_back((^b) ^ pt);
        exp_q.push_back(1'b1);
    endtask

    task automatic start_frame(input logic [7:0] b, input bit pe, input bit pt, input bit stk, input bit hold);
        @(negedge clk);
        p_data = b; pen = pe; ptyp = pt; stuck = stk; ser_byte = b; dv = 1'b1;
        push_exp(b, pe, pt, stk);
        @(negedge clk);
        if (!hold) dv = 1'b0;
    endtask

    task automatic collect_frame(input string name, input int eb, input int es, input int ee, input int ep);
        int nb = 0, ns = 0, ne = 0, np = 0;
        bit b, e;
        for (int c = 0; c < 40; c++) begin
            b = busy;
            if (!b) break;
            nb++;
            ns += int'(ser_en);
            ne += int'(ferr);
            np += int'(mux_sel == 2'b11);
            @(negedge clk);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s tx: extra bit %b, none expected", name, tx);
            end else begin
                e = exp_q.pop_front();
                if (tx !== e) begin
                    bad++;
                    $display("FAIL %s tx bit %0d: got %b expected %b", name, c, tx, e);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s tx: %0d expected bits never seen", name, exp_q.size());
            exp_q.delete();
        end
        total++;
        if (nb != eb) begin bad++; $display("FAIL %s busy cycles: got %0d expected %0d", name, nb, eb); end
        total++;
        if (ns != es) begin bad++; $display("FAIL %s ser_en cycles: got %0d expected %0d", name, ns, es); end
        total++;
        if (ne != ee) begin bad++; $display("FAIL %s frame_err cycles: got %0d expected %0d", name, ne, ee); end
        total++;
        if (np != ep) begin bad++; $display("FAIL %s parity-select cycles: got %0d expected %0d", name, np, ep); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, ser_en, mux_sel, tx, ferr} !== 6'b0_0_01_1_0) begin
            bad++; $display("FAIL reset_held outputs: got %b expected 000110", {busy, ser_en, mux_sel, tx, ferr});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({busy, ser_en, mux_sel, tx, ferr} !== 6'b0_0_01_1_0) begin
                bad++; $display("FAIL idle_%0d outputs: got %b expected 000110", i, {busy, ser_en, mux_sel, tx, ferr});
            end
        end
    endtask

    task automatic test_no_parity();
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        collect_frame("a5_nopar", 10, 8, 0, 0);
        start_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        collect_frame("3c_nopar", 10, 8, 0, 0);
    endtask

    task automatic test_parity();
        start_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        collect_frame("07_even", 10 + int'(HAS_PAR), 8, 0, int'(HAS_PAR));
        start_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        collect_frame("07_odd", 10 + int'(HAS_PAR), 8, 0, int'(HAS_PAR));
        start_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        collect_frame("00_odd", 10 + int'(HAS_PAR), 8, 0, int'(HAS_PAR));
    endtask

    task automatic test_back_to_back();
        start_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1);
        collect_frame("hold_first", 10, 8, 0, 0);
        push_exp(8'h96, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL hold_reaccept busy: got %b expected 1", busy); end
        dv = 1'b0;
        collect_frame("hold_second", 10, 8, 0, 0);
    endtask

    task automatic test_watchdog();
        start_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        collect_frame("wdog_stuck", 12, 10, 1, 0);
        stuck = 1'b0;
        start_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        collect_frame("after_wdog", 10, 8, 0, 0);
    endtask

    task automatic test_reset_mid();
        start_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({ser_en, tx} !== 2'b10) begin bad++; $display("FAIL mid_pre_reset ser_en,tx: got %b expected 10", {ser_en, tx}); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, ser_en, mux_sel, tx, ferr} !== 6'b0_0_01_1_0) begin
            bad++; $display("FAIL mid_reset outputs: got %b expected 000110", {busy, ser_en, mux_sel, tx, ferr});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        collect_frame("after_reset", 10 + int'(HAS_PAR), 8, 0, int'(HAS_PAR));
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
